// File: rtl/uart_cmd_parser.sv
// UART command engine: frames 5-byte commands, checks them, executes against a
// 16x8 register file, mirrors writes to the config bus and returns a 4-byte response.
module uart_cmd_parser #(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int NUM_REGS       = 16
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_wr_data,
    output logic              tx_wr,
    output logic              cfg_wr,
    output logic [3:0]        cfg_addr,
    output logic [DATA_W-1:0] cfg_wdata,
    output logic              busy,
    output logic [7:0]        err_cnt,
    output logic [7:0]        drop_cnt
);

    // state  | meaning
    // IDLE   | hunting for 0xA5 sync, other bytes ignored
    // CMD    | waiting for command byte
    // ADDR   | waiting for address byte
    // DATA   | waiting for data byte
    // CSUM   | waiting for checksum byte, frame verdict latched on accept
    // EXEC   | one cycle: register write / read, response formed
    // RESP   | issuing response bytes 0..3 under tx_ready
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_CSUM, S_EXEC, S_RESP
    } state_t;

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] SYNC_RX  = DATA_W'(8'hA5);
    localparam logic [DATA_W-1:0] SYNC_TX  = DATA_W'(8'h5A);
    localparam logic [DATA_W-1:0] CMD_WR   = DATA_W'(8'h01);
    localparam logic [DATA_W-1:0] CMD_RD   = DATA_W'(8'h02);
    localparam logic [DATA_W-1:0] ST_OK    = DATA_W'(8'h00);
    localparam logic [DATA_W-1:0] ST_CSUM  = DATA_W'(8'hE1);
    localparam logic [DATA_W-1:0] ST_CMD   = DATA_W'(8'hE2);
    localparam logic [DATA_W-1:0] ST_ADDR  = DATA_W'(8'hE3);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] cmd_q, addr_q, data_q;
    logic [DATA_W-1:0] status_q, rdata_q, status_eval, tx_byte;
    logic [1:0]        idx_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              in_frame, to_expire, err_inc, drop_inc;

    assign in_frame  = (state_q == S_CMD) || (state_q == S_ADDR) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
    assign to_expire = in_frame && !rx_valid && (to_cnt_q == '0);
    assign err_inc   = ((state_q == S_EXEC) && (status_q != ST_OK)) || to_expire;
    assign drop_inc  = rx_valid && ((state_q == S_EXEC) || (state_q == S_RESP));

    // Verdict uses the incoming checksum byte so cfg_wr can be registered into EXEC.
    always_comb begin
        status_eval = ST_OK;
        if ((cmd_q ^ addr_q ^ data_q) != rx_data)
            status_eval = ST_CSUM;
        else if ((cmd_q != CMD_WR) && (cmd_q != CMD_RD))
            status_eval = ST_CMD;
        else if (addr_q[DATA_W-1:4] != '0)
            status_eval = ST_ADDR;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rx_valid && (rx_data == SYNC_RX)) state_d = S_CMD;
            S_CMD:  if (rx_valid) state_d = S_ADDR; else if (to_expire) state_d = S_IDLE;
            S_ADDR: if (rx_valid) state_d = S_DATA; else if (to_expire) state_d = S_IDLE;
            S_DATA: if (rx_valid) state_d = S_CSUM; else if (to_expire) state_d = S_IDLE;
            S_CSUM: if (rx_valid) state_d = S_EXEC; else if (to_expire) state_d = S_IDLE;
            S_EXEC: state_d = S_RESP;
            S_RESP: if (tx_ready && (idx_q == 2'd3)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_byte = SYNC_TX;
        case (idx_q)
            2'd0: tx_byte = SYNC_TX;
            2'd1: tx_byte = status_q;
            2'd2: tx_byte = rdata_q;
            2'd3: tx_byte = status_q ^ rdata_q;
            default: tx_byte = SYNC_TX;
        endcase
    end

    // Gating with rstN keeps the reset cycle itself free of a stray write strobe.
    assign tx_wr      = rstN && (state_q == S_RESP) && tx_ready;
    assign tx_wr_data = (state_q == S_RESP) ? tx_byte : '0;
    assign busy       = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rstN) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            status_q  <= '0;
            rdata_q   <= '0;
            idx_q     <= '0;
            to_cnt_q  <= '0;
            cfg_wr    <= 1'b0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            err_cnt   <= '0;
            drop_cnt  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            cfg_wr <= 1'b0;
            if (in_frame) begin
                if (rx_valid)             to_cnt_q <= TO_LOAD;
                else if (to_cnt_q != '0)  to_cnt_q <= to_cnt_q - TO_W'(1);
            end else if ((state_q == S_IDLE) && rx_valid && (rx_data == SYNC_RX)) begin
                to_cnt_q <= TO_LOAD;
            end
            case (state_q)
                S_CMD:  if (rx_valid) cmd_q  <= rx_data;
                S_ADDR: if (rx_valid) addr_q <= rx_data;
                S_DATA: if (rx_valid) data_q <= rx_data;
                S_CSUM: if (rx_valid) begin
                    status_q <= status_eval;
                    if ((status_eval == ST_OK) && (cmd_q == CMD_WR)) begin
                        cfg_wr    <= 1'b1;
                        cfg_addr  <= addr_q[3:0];
                        cfg_wdata <= data_q;
                    end
                end
                S_EXEC: begin
                    idx_q <= 2'd0;
                    if (status_q != ST_OK) begin
                        rdata_q <= '0;
                    end else if (cmd_q == CMD_WR) begin
                        regs[addr_q[3:0]] <= data_q;
                        rdata_q           <= data_q;
                    end else begin
                        rdata_q <= regs[addr_q[3:0]];
                    end
                end
                S_RESP: if (tx_ready) idx_q <= idx_q + 2'd1;
                default: ;
            endcase
            if (err_inc && (err_cnt != 8'hFF))   err_cnt  <= err_cnt + 8'd1;
            if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized self-checking bench for uart_cmd_parser against a frame-level model.
module tb_uart_cmd_parser;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_wr_data, cfg_wdata, err_cnt, drop_cnt;
    logic       tx_wr, cfg_wr, busy;
    logic [3:0] cfg_addr;

    uart_cmd_parser #(.DATA_W(8), .TIMEOUT_CYCLES(TO), .NUM_REGS(16)) dut (
        .clk(clk), .rstN(rstN), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_ready(tx_ready), .tx_wr_data(tx_wr_data), .tx_wr(tx_wr),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .busy(busy), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [7:0]  m_regs [16];
    int          m_err = 0, m_drop = 0;
    logic [7:0]  exp_q [$];
    bit          exp_wr;
    logic [11:0] exp_cfg;
    int          csum_cyc;

    // Monitor state
    logic [7:0]  got_q [$];
    logic [11:0] cfg_q [$];
    int first_tx_cyc = -1, cfg_cyc = -1, idle_cyc = -1, proto_bad = 0;
    bit prev_busy = 1'b0;
    bit rdy_rand = 1'b0;

    initial forever begin
        @(negedge clk);
        if (tx_wr) begin
            if (got_q.size() == 0) first_tx_cyc = cyc;
            got_q.push_back(tx_wr_data);
            if (!tx_ready) proto_bad++;
        end
        if (cfg_wr) begin
            cfg_q.push_back({cfg_addr, cfg_wdata});
            cfg_cyc = cyc;
        end
        if (prev_busy && !busy) idle_cyc = cyc;
        prev_busy = busy;
    end

    initial forever begin
        @(posedge clk); #2;
        if (rdy_rand) tx_ready = 1'($urandom_range(0, 1));
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_err = 0; m_drop = 0;
    endtask

    task automatic start_frame(input logic [7:0] c, a, d, cs, input int gapmax, input int cmd_gap);
        logic [7:0] st, rd;
        logic [7:0] fb [4];
        st = 8'h00; rd = 8'h00; exp_wr = 1'b0; exp_cfg = '0;
        if ((c ^ a ^ d) != cs)          st = 8'hE1;
        else if (c != 8'h01 && c != 8'h02) st = 8'hE2;
        else if (a >= 8'd16)            st = 8'hE3;
        if (st == 8'h00) begin
            if (c == 8'h01) begin
                rd = d; m_regs[a[3:0]] = d; exp_wr = 1'b1; exp_cfg = {a[3:0], d};
            end else begin
                rd = m_regs[a[3:0]];
            end
        end else begin
            m_err = sat_inc(m_err);
        end
        exp_q = '{8'h5A, st, rd, st ^ rd};
        got_q.delete(); cfg_q.delete();
        first_tx_cyc = -1; cfg_cyc = -1; idle_cyc = -1;
        fb = '{c, a, d, cs};
        send_byte(8'hA5);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) csum_cyc = cyc;
            send_byte(fb[i]);
            if (i < 3) begin
                int g;
                g = (i == 0 && cmd_gap >= 0) ? cmd_gap : $urandom_range(0, gapmax);
                repeat (g) step();
            end
        end
    endtask

    task automatic finish_frame(input bit timed);
        int k;
        k = 0;
        do begin
            @(negedge clk); k++;
        end while (!(got_q.size() >= 4 && busy == 1'b0) && k < 200);
        step();
        chk("resp_done", (k < 200), 1);
        chk("resp_len", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("resp_byte%0d", i), (got_q.size() > i) ? got_q[i] : 32'hDEAD, exp_q[i]);
        chk("cfg_count", cfg_q.size(), exp_wr ? 1 : 0);
        if (exp_wr && cfg_q.size() > 0) chk("cfg_addr_data", cfg_q[0], exp_cfg);
        chk("err_cnt", err_cnt, m_err);
        chk("drop_cnt", drop_cnt, m_drop);
        if (timed) begin
            chk("first_tx_cycle", first_tx_cyc, csum_cyc + 2);
            chk("busy_fall_cycle", idle_cyc, csum_cyc + 6);
            if (exp_wr) chk("cfg_wr_cycle", cfg_cyc, csum_cyc + 1);
        end
    endtask

    task automatic run_frame(input logic [7:0] c, a, d, cs, input bit timed);
        start_frame(c, a, d, cs, 0, -1);
        finish_frame(timed);
    endtask

    initial begin
        model_reset();
        repeat (3) step();
        @(negedge clk);
        chk("rst_tx_wr", tx_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_wr", cfg_wr, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_tx_data", tx_wr_data, 0);
        step();
        rstN = 1'b1;
        step();

        // Write, read-back, unwritten read
        run_frame(8'h01, 8'h03, 8'h7E, 8'h7C, 1'b1);
        run_frame(8'h02, 8'h03, 8'h00, 8'h01, 1'b1);
        run_frame(8'h02, 8'h05, 8'h00, 8'h07, 1'b1);

        // Error priority, then confirm register untouched
        run_frame(8'h01, 8'h03, 8'h7E, 8'h00, 1'b1);
        run_frame(8'h07, 8'h03, 8'h00, 8'h04, 1'b1);
        run_frame(8'h01, 8'h20, 8'h11, 8'h30, 1'b1);
        chk("err_cnt_after_errors", err_cnt, 3);
        run_frame(8'h02, 8'h03, 8'h00, 8'h01, 1'b1);

        // Timeout: last byte at L, still busy at L+TO, idle at L+TO+1
        got_q.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (TO - 1) step();
        @(negedge clk);
        chk("timeout_busy_before", busy, 1);
        step();
        @(negedge clk);
        m_err = sat_inc(m_err);
        chk("timeout_busy_after", busy, 0);
        chk("timeout_err_cnt", err_cnt, m_err);
        chk("timeout_no_tx", got_q.size(), 0);
        step();
        send_byte(8'h00);
        send_byte(8'hFF);
        run_frame(8'h01, 8'h09, 8'hC3, 8'hCB, 1'b1);

        // Byte arriving in the expiry cycle is accepted
        start_frame(8'h01, 8'h07, 8'h33, 8'h35, 0, TO - 1);
        finish_frame(1'b1);

        // Backpressure pattern plus two dropped bytes (0xA5 must not resync)
        begin
            bit pat [7];
            pat = '{1, 0, 0, 1, 0, 1, 1};
            start_frame(8'h02, 8'h07, 8'h00, 8'h05, 0, -1);
            step();
            for (int i = 0; i < 7; i++) begin
                tx_ready = pat[i];
                if (i == 1 || i == 2) begin
                    rx_data = 8'hA5; rx_valid = 1'b1;
                    m_drop = sat_inc(m_drop);
                end
                step();
                rx_valid = 1'b0;
            end
            tx_ready = 1'b1;
            finish_frame(1'b0);
            chk("drop_cnt_two", drop_cnt, 2);
        end

        // Reset in the middle of the response
        begin
            int k;
            start_frame(8'h01, 8'h0A, 8'h55, 8'h5E, 0, -1);
            k = 0;
            do begin @(negedge clk); k++; end while (got_q.size() < 2 && k < 50);
            chk("midresp_reached", (k < 50), 1);
            step();
            rstN = 1'b0;
            step();
            rstN = 1'b1;
            model_reset();
            repeat (10) step();
            @(negedge clk);
            chk("midresp_no_more_tx", got_q.size(), 2);
            chk("midresp_busy", busy, 0);
            chk("midresp_err_cnt", err_cnt, 0);
            chk("midresp_drop_cnt", drop_cnt, 0);
            step();
            run_frame(8'h02, 8'h03, 8'h00, 8'h01, 1'b1);
            run_frame(8'h02, 8'h0A, 8'h00, 8'h08, 1'b1);
        end

        // Randomized frames with random backpressure, gaps, garbage and drops
        rdy_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [7:0] c, a, d, cs;
            int kind;
            kind = $urandom_range(0, 5);
            c = (kind == 1 || kind == 5) ? 8'h02 : 8'h01;
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            if (kind == 3) c = 8'($urandom_range(3, 255));
            if (kind == 4) a = 8'($urandom_range(16, 255));
            cs = c ^ a ^ d;
            if (kind == 2) cs = cs ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) begin
                logic [7:0] g;
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                send_byte(g);
            end
            start_frame(c, a, d, cs, 3, -1);
            if ($urandom_range(0, 2) == 0) begin
                send_byte(8'($urandom_range(0, 255)));
                m_drop = sat_inc(m_drop);
            end
            finish_frame(1'b0);
        end
        rdy_rand = 1'b0;
        step();
        tx_ready = 1'b1;

        chk("tx_wr_only_with_ready", proto_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command engine that sits directly downstream of the UART receive FIFO and upstream of the UART transmit FIFO. It frames incoming bytes into fixed 5-byte command packets and validates each packet's checksum, command and address. It executes reads and writes against an internal 16×8 register file, mirrors writes to a configuration bus, and returns a 4-byte response packet through the transmit path.

## Interface
Parameters:
- DATA_W, 8, byte width; equals the UART FIFO width; only 8 is supported
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles; minimum 2
- NUM_REGS, 16, register file depth; fixed, address field uses bits [3:0]

Ports:
- clk  in  1  system clock
- rstN  in  1  synchronous active-low reset
- rx_data  in  DATA_W  received byte from the RX FIFO
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- tx_ready  in  1  TX path can accept a byte this cycle; tie high if no backpressure is available
- tx_wr_data  out  DATA_W  response byte to the TX FIFO
- tx_wr  out  1  write strobe for tx_wr_data
- cfg_wr  out  1  one-cycle write pulse to the configuration bus
- cfg_addr  out  4  configuration write address
- cfg_wdata  out  DATA_W  configuration write data
- busy  out  1  high in any state other than IDLE
- err_cnt  out  8  saturating count of rejected frames
- drop_cnt  out  8  saturating count of bytes dropped while in EXEC or RESP

## Operation
- Command frame: 0xA5 sync, CMD, ADDR, DATA, CSUM, where CSUM = CMD ^ ADDR ^ DATA.
- Commands:
  - 0x01 = write: regfile[ADDR[3:0]] <= DATA.
  - 0x02 = read: the DATA byte is ignored but still included in CSUM.
- Response frame: 0x5A, STATUS, RDATA, RSUM, where RSUM = STATUS ^ RDATA.
- STATUS codes and the RDATA returned with each:
  - 0x00 = OK. Write echoes DATA; read returns the register value.
  - 0xE1 = bad checksum. RDATA = 0x00.
  - 0xE2 = unknown CMD. RDATA = 0x00.
  - 0xE3 = ADDR ≥ 16. RDATA = 0x00.
- Error check priority: checksum first, then CMD, then ADDR. Any error has no register or cfg side effect and increments err_cnt.
- States: IDLE → CMD → ADDR → DATA → CSUM → EXEC → RESP → IDLE.
  - IDLE: rx_valid with 0xA5 goes to CMD. Any other byte is discarded silently and not counted.
  - CMD, ADDR, DATA: each rx_valid latches the byte and advances one state.
  - CSUM: rx_valid latches CSUM and goes to EXEC.
  - EXEC: lasts exactly one cycle. Evaluates the frame, performs the write, forms the response, and goes to RESP.
  - RESP: 2-bit index 0..3. One byte is issued per cycle in which tx_ready=1. After index 3 is issued, go to IDLE.
- A byte value of 0xA5 received in CMD..CSUM is treated as data, not as a resync.
- Timeout:
  - A counter clears on entry to CMD and on every accepted byte in CMD..CSUM.
  - If it reaches TIMEOUT_CYCLES−1 with no rx_valid in the same cycle, go to IDLE, increment err_cnt, and send no response.
  - rx_valid in the expiry cycle wins: the byte is accepted and no timeout occurs.
- rx_valid during EXEC or RESP: the byte is dropped and drop_cnt increments. Both counters saturate at 0xFF.
- Reset values:
  - State = IDLE; all outputs 0; counters 0; register file all 0x00.
  - Reset asserted mid-frame or mid-response aborts immediately. No further tx_wr occurs after the reset cycle.

## Timing
- Checksum byte accepted in cycle N:
  - EXEC in cycle N+1; cfg_wr pulses in N+1 for a valid write, with cfg_addr and cfg_wdata valid in that same cycle.
  - The register file updates at the end of N+1.
  - The first tx_wr (0x5A) occurs in N+2 if tx_ready=1.
- A valid write followed immediately by a read of the same address returns the new value.
- With tx_ready held high, the 4 response bytes go out on N+2..N+5, and busy falls in N+6.
- tx_wr is asserted only when tx_ready=1. tx_wr_data is stable while tx_ready=0. tx_ready is sampled combinationally in RESP.
- cfg_addr and cfg_wdata hold their last written values between pulses.
- Back-to-back bytes (rx_valid on consecutive cycles) are accepted in all frame states.

## Test plan
- Write: A5 01 03 7E 7C → cfg_wr pulse with addr 3, data 0x7E. Response 5A 00 7E 7E; err_cnt 0.
- Read: after the write above, A5 02 03 00 01 → response 5A 00 7E 7E, no cfg_wr. A read of unwritten addr 5 returns 5A 00 00 00.
- Error priority: A5 01 03 7E 00 → 5A E1 00 E1. A5 07 03 00 04 → 5A E2 00 E2. A5 01 20 11 30 → 5A E3 00 E3. err_cnt = 3; the register file is unchanged.
- Timeout and resync: with TIMEOUT_CYCLES=16, send A5 01 then idle 16 cycles → IDLE, err_cnt +1, no tx_wr. Then send garbage 00 FF, then a valid frame → normal response.
- Backpressure and drops: toggle tx_ready 1,0,0,1,0,1,1 during RESP → exactly 4 tx_wr pulses in order 5A, STATUS, RDATA, RSUM. Two rx_valid bytes during RESP → drop_cnt = 2.
- Reset mid-response: deassert rstN after 2 response bytes → no further tx_wr, all counters and registers 0, busy = 0. The next valid frame responds normally.
